// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: control decode, register file with write-back
// bypass, load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REG  = 16,
  parameter int LINK_REG = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wreg,
  input  logic             flush,
  output logic             if_stall,
  output logic             id_valid,
  output logic             id_regwrite,
  output logic             id_memtoreg,
  output logic             id_memread,
  output logic             id_memwrite,
  output logic             id_branch,
  output logic             id_bne,
  output logic             id_jump,
  output logic             id_jr,
  output logic             id_jal,
  output logic             id_alusrc,
  output logic [1:0]       id_aluop,
  output logic [XLEN-1:0]  id_rs_data,
  output logic [XLEN-1:0]  id_rt_data,
  output logic [XLEN-1:0]  id_imm,
  output logic [4:0]       id_rs,
  output logic [4:0]       id_rt,
  output logic [4:0]       id_wreg,
  output logic [4:0]       id_shamt,
  output logic [5:0]       id_opcode,
  output logic [5:0]       id_funct,
  output logic [XLEN-1:0]  id_pc8,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memtoreg;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic            bne;
    logic            jump;
    logic            jr;
    logic            jal;
    logic            alusrc;
    logic [1:0]      aluop;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      wreg;
    logic [4:0]      shamt;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [XLEN-1:0] pc8;
  } idex_t;

  logic [5:0]       opcode_s;
  logic [5:0]       funct_s;
  logic [4:0]       rs_s;
  logic [4:0]       rt_s;
  logic [4:0]       rd_s;
  logic [4:0]       shamt_s;
  logic [15:0]      imm16_s;
  logic             wb_wen_s;
  logic             uses_rt_s;
  logic             hazard_s;
  logic [XLEN-1:0]  rs_data_s;
  logic [XLEN-1:0]  rt_data_s;
  logic [XLEN-1:0]  regs_r [32];
  idex_t            dec_s;
  idex_t            idex_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  assign opcode_s = if_instr[31:26];
  assign rs_s     = if_instr[25:21];
  assign rt_s     = if_instr[20:16];
  assign rd_s     = if_instr[15:11];
  assign shamt_s  = if_instr[10:6];
  assign funct_s  = if_instr[5:0];
  assign imm16_s  = if_instr[15:0];

  // Unimplemented indices never get written, so they hold zero and read as zero.
  assign wb_wen_s = wb_we && (wb_addr != 5'd0) && ({1'b0, wb_addr} < 6'(NUM_REG));

  // Register file storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rst) begin
        regs_r[i] <= '0;
      end else if (wb_wen_s && (wb_addr == 5'(i))) begin
        regs_r[i] <= wb_data;
      end else begin
        regs_r[i] <= regs_r[i];
      end
    end
  end

  assign rs_data_s = (wb_wen_s && (wb_addr == rs_s)) ? wb_data : regs_r[rs_s];
  assign rt_data_s = (wb_wen_s && (wb_addr == rt_s)) ? wb_data : regs_r[rt_s];

  // rt is a source only for R-type, branches and stores.
  assign uses_rt_s = (opcode_s == OP_R) || (opcode_s == OP_BEQ) ||
                     (opcode_s == OP_BNE) || (opcode_s == OP_SW);
  assign hazard_s  = if_valid && ex_memread && (ex_wreg != 5'd0) &&
                     ((ex_wreg == rs_s) || (uses_rt_s && (ex_wreg == rt_s)));
  assign if_stall  = hazard_s && !flush;

  // Instruction decode into the next ID/EX contents.
  always_comb begin
    dec_s         = '0;
    dec_s.valid   = if_valid;
    dec_s.rs_data = rs_data_s;
    dec_s.rt_data = rt_data_s;
    dec_s.imm     = XLEN'($signed(imm16_s));
    dec_s.rs      = rs_s;
    dec_s.rt      = rt_s;
    dec_s.shamt   = shamt_s;
    dec_s.opcode  = opcode_s;
    dec_s.funct   = funct_s;
    dec_s.pc8     = if_pc + XLEN'(8);
    case (opcode_s)
      OP_R: begin
        dec_s.aluop = 2'b10;
        dec_s.wreg  = rd_s;
        if (funct_s == FN_JR) begin
          dec_s.jump = 1'b1;
          dec_s.jr   = 1'b1;
        end else begin
          dec_s.regwrite = 1'b1;
        end
      end
      OP_LW: begin
        dec_s.regwrite = 1'b1;
        dec_s.memtoreg = 1'b1;
        dec_s.memread  = 1'b1;
        dec_s.alusrc   = 1'b1;
        dec_s.wreg     = rt_s;
      end
      OP_SW: begin
        dec_s.memwrite = 1'b1;
        dec_s.alusrc   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_s.branch = 1'b1;
        dec_s.bne    = (opcode_s == OP_BNE);
        dec_s.aluop  = 2'b01;
      end
      OP_ADDI, OP_SLTI: begin
        dec_s.regwrite = 1'b1;
        dec_s.alusrc   = 1'b1;
        dec_s.wreg     = rt_s;
        dec_s.aluop    = (opcode_s == OP_SLTI) ? 2'b11 : 2'b00;
      end
      OP_ANDI, OP_ORI: begin
        dec_s.regwrite = 1'b1;
        dec_s.alusrc   = 1'b1;
        dec_s.wreg     = rt_s;
        dec_s.aluop    = 2'b11;
        dec_s.imm      = XLEN'(imm16_s);
      end
      OP_J: begin
        dec_s.jump = 1'b1;
      end
      OP_JAL: begin
        dec_s.jump     = 1'b1;
        dec_s.jal      = 1'b1;
        dec_s.regwrite = 1'b1;
        dec_s.wreg     = 5'(LINK_REG);
      end
      default: begin
        dec_s.aluop = 2'b00;
      end
    endcase
  end

  // ID/EX pipeline register; flush, hazard and empty slots all become bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_r <= '0;
    end else if (flush || hazard_s || !if_valid) begin
      idex_r <= '0;
    end else begin
      idex_r <= dec_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (if_stall && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign id_valid    = idex_r.valid;
  assign id_regwrite = idex_r.regwrite;
  assign id_memtoreg = idex_r.memtoreg;
  assign id_memread  = idex_r.memread;
  assign id_memwrite = idex_r.memwrite;
  assign id_branch   = idex_r.branch;
  assign id_bne      = idex_r.bne;
  assign id_jump     = idex_r.jump;
  assign id_jr       = idex_r.jr;
  assign id_jal      = idex_r.jal;
  assign id_alusrc   = idex_r.alusrc;
  assign id_aluop    = idex_r.aluop;
  assign id_rs_data  = idex_r.rs_data;
  assign id_rt_data  = idex_r.rt_data;
  assign id_imm      = idex_r.imm;
  assign id_rs       = idex_r.rs;
  assign id_rt       = idex_r.rt;
  assign id_wreg     = idex_r.wreg;
  assign id_shamt    = idex_r.shamt;
  assign id_opcode   = idex_r.opcode;
  assign id_funct    = idex_r.funct;
  assign id_pc8      = idex_r.pc8;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule
